// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 (7,5) convolutional encoder with framed input, two zero tail bits
// and a one-deep registered symbol output with valid/ready flow control.
module conv_encoder #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       din_valid,
  input  logic       din,
  output logic       din_ready,
  output logic       sym_valid,
  output logic [1:0] sym,
  input  logic       sym_ready,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      enc_q, enc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      tail_q, tail_d;
  logic [1:0]      sym_q, sym_d;
  logic            sym_valid_q, sym_valid_d;
  logic            free_s, hs_s, data_acc_s, tail_load_s, load_s, bit_s;

  // Code symbol {c1,c0} for input bit d with encoder state s = {s1,s0}.
  function automatic logic [1:0] encode(input logic d, input logic [1:0] s);
    encode = {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  assign free_s      = !sym_valid_q || sym_ready;
  assign hs_s        = sym_valid_q && sym_ready;
  assign data_acc_s  = (state_q == DATA) && din_valid && free_s;
  assign tail_load_s = (state_q == TAIL) && free_s && (tail_q != 2'd2);
  assign load_s      = data_acc_s || tail_load_s;
  assign bit_s       = (state_q == DATA) ? din : 1'b0;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enc_q       <= 2'b00;
      cnt_q       <= '0;
      tail_q      <= 2'd0;
      sym_q       <= 2'b00;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (st) state_d = DATA;
        else    state_d = IDLE;
      end
      DATA: begin
        if (data_acc_s && (cnt_q == LAST_BIT)) state_d = TAIL;
        else                                   state_d = DATA;
      end
      TAIL: begin
        // Leave only once the second tail symbol has actually been consumed.
        if (hs_s && (tail_q == 2'd2)) state_d = DONE;
        else                          state_d = TAIL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Encoder state, counters and output-register next values.
  always_comb begin
    enc_d       = enc_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    if ((state_q == IDLE) && st) begin
      enc_d  = 2'b00;
      cnt_d  = '0;
      tail_d = 2'd0;
    end else if (load_s) begin
      // A load wins over a simultaneous handshake so the pipe sustains one symbol per cycle.
      enc_d       = {bit_s, enc_q[1]};
      sym_d       = encode(bit_s, enc_q);
      sym_valid_d = 1'b1;
      if (data_acc_s) cnt_d  = cnt_q + CW'(1);
      else            tail_d = tail_q + 2'd1;
    end else if (hs_s) begin
      sym_valid_d = 1'b0;
    end else begin
      sym_valid_d = sym_valid_q;
    end
  end

  // Output decode.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    din_ready = (state_q == DATA) && free_s;
    sym       = sym_q;
    sym_valid = sym_valid_q;
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: stimulus pushes expected (7,5) symbols computed from
// the generator polynomials, a monitor pops and compares on every output handshake.
module tb_conv_encoder;

  logic       clk;
  logic       rst;
  logic       st, din_valid, din, sym_ready;
  logic       din_ready, sym_valid, busy, done;
  logic [1:0] sym;

  logic       st8, din_valid8, din8, sym_ready8;
  logic       din_ready8, sym_valid8, busy8, done8;
  logic [1:0] sym8;

  int checks   = 0;
  int failures = 0;
  int q[$];
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_left = 0;

  conv_encoder #(.FRAME_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .st(st), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .busy(busy), .done(done)
  );

  conv_encoder #(.FRAME_LEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .st(st8), .din_valid(din_valid8), .din(din8),
    .din_ready(din_ready8), .sym_valid(sym_valid8), .sym(sym8), .sym_ready(sym_ready8),
    .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: c1 = b[i]+b[i-1]+b[i-2], c0 = b[i]+b[i-2] (mod 2), two zero tail bits appended.
  task automatic push_model(input logic [15:0] bits, input int n);
    int b[$];
    for (int i = 0; i < n; i++) b.push_back(int'(bits[i]));
    b.push_back(0);
    b.push_back(0);
    for (int i = 0; i < n + 2; i++) begin
      int p1 = (i >= 1) ? b[i-1] : 0;
      int p2 = (i >= 2) ? b[i-2] : 0;
      q.push_back(2 * ((b[i] + p1 + p2) % 2) + ((b[i] + p2) % 2));
    end
  endtask

  // Consumer-side ready generation.
  initial begin
    sym_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: sym_ready = 1'($urandom_range(0, 1));
        2: begin
          if (stall_left > 0 && sym_valid) begin
            sym_ready = 1'b0;
            stall_left--;
          end else begin
            sym_ready = 1'b1;
          end
        end
        default: sym_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, done counting.
  initial begin
    bit         prev_stall;
    logic [1:0] prev_sym;
    prev_stall = 1'b0;
    prev_sym   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", int'(sym_valid), 1);
          check("stall_sym_held", int'(sym), int'(prev_sym));
        end
        if (sym_valid && sym_ready) begin
          check("sym_expected_avail", int'(q.size() > 0), 1);
          if (q.size() > 0) check("sym_value", int'(sym), q.pop_front());
        end
        if (sym_valid && !sym_ready) check("stall_din_ready_low", int'(din_ready), 0);
        prev_stall = sym_valid && !sym_ready;
        prev_sym   = sym;
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_frame(input logic [15:0] bits, input int n, input bit rand_valid,
                           input bit st_noise);
    int i, guard;
    bit acc, seen;
    done_cnt = 0;
    @(posedge clk); #1;
    check("idle_before_start", int'(busy), 0);
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    check("busy_after_start", int'(busy), 1);
    i = 0;
    guard = 0;
    while (i < n && guard < 500) begin
      din_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      din       = din_valid ? bits[i] : 1'($urandom_range(0, 1));
      st        = st_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    din_valid = 1'b0;
    st        = 1'b0;
    check("data_accept_in_time", int'(guard < 500), 1);
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      guard++;
    end
    check("done_seen", int'(seen), 1);
    if (seen && st_noise) st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    @(negedge clk);
    check("idle_after_done", int'(busy), 0);
    check("done_once", done_cnt, 1);
    check("all_symbols_out", q.size(), 0);
    q.delete();
  endtask

  initial begin
    logic [15:0] b;
    int i, guard, n8, d8;
    bit acc;
    rst = 1'b1;
    st = 1'b0; din_valid = 1'b0; din = 1'b0;
    st8 = 1'b0; din_valid8 = 1'b0; din8 = 1'b0; sym_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym", int'(sym), 0);
    check("rst_din_ready", int'(din_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Directed frame 1,0,1,1 -> 11,10,00,01 then tail 01,11.
    ready_mode = 0;
    q.push_back(3); q.push_back(2); q.push_back(0);
    q.push_back(1); q.push_back(1); q.push_back(3);
    run_frame(16'h000D, 4, 1'b0, 1'b0);

    // Same frame with a 3-cycle consumer stall after the first symbol.
    ready_mode = 2;
    stall_left = 3;
    q.push_back(3); q.push_back(2); q.push_back(0);
    q.push_back(1); q.push_back(1); q.push_back(3);
    run_frame(16'h000D, 4, 1'b0, 1'b0);
    ready_mode = 0;

    // st pulses during DATA and DONE.
    b = 16'($urandom_range(0, 15));
    push_model(b, 4);
    run_frame(b, 4, 1'b0, 1'b1);

    // Reset after two accepted data bits.
    b = 16'h000D;
    push_model(b, 4);
    @(posedge clk); #1;
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    i = 0;
    guard = 0;
    while (i < 2 && guard < 50) begin
      din_valid = 1'b1;
      din = b[i];
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    din_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sym_valid", int'(sym_valid), 0);
    check("midrst_sym", int'(sym), 0);
    check("midrst_din_ready", int'(din_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    q.push_back(3); q.push_back(2); q.push_back(0);
    q.push_back(1); q.push_back(1); q.push_back(3);
    run_frame(16'h000D, 4, 1'b0, 1'b0);

    // Random data, random din_valid, random sym_ready.
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      b = 16'($urandom_range(0, 15));
      push_model(b, 4);
      run_frame(b, 4, 1'b1, 1'(k % 2));
    end
    ready_mode = 0;

    // FRAME_LEN=8 all-zero frame: 10 symbols of 00.
    @(posedge clk); #1;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    din_valid8 = 1'b1;
    din8 = 1'b0;
    n8 = 0;
    d8 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sym_valid8) begin
        check("fl8_sym_zero", int'(sym8), 0);
        n8++;
      end
      if (done8) d8++;
    end
    din_valid8 = 1'b0;
    check("fl8_symbol_count", n8, 10);
    check("fl8_done_once", d8, 1);
    check("fl8_idle", int'(busy8), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of information bits per frame (>=1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 st  input  1  frame start pulse; sampled only in IDLE.
REQ-005 din_valid  input  1  information bit on din is valid.
REQ-006 din  input  1  information bit.
REQ-007 din_ready  output  1  encoder accepts din this cycle.
REQ-008 sym_valid  output  1  sym holds a valid code symbol.
REQ-009 sym  output  2  code symbol {c1,c0} (rate 1/2).
REQ-010 sym_ready  input  1  downstream consumer (decoder/channel) accepts sym this cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 Code: K=3, generators g1=111 (octal 7), g0=101 (octal 5); encoder state {s1,s0}, s1 = most recent past bit.
REQ-014 For input bit d: c1 = d^s1^s0, c0 = d^s0; next state = {d,s1}.
REQ-015 FSM states IDLE, DATA, TAIL, DONE.
REQ-016 IDLE: st=1 -> DATA, encoder state cleared to 00, bit counter cleared; st=0 -> stay.
REQ-017 Output register "free" condition: free = !sym_valid || sym_ready.
REQ-018 DATA: din_ready = free; din_ready = 0 in all other states.
REQ-019 DATA accept (din_valid && din_ready): sym <= {c1,c0}, sym_valid <= 1, encoder state and bit counter update, all in the same edge; symbol visible the cycle after acceptance (latency 1).
REQ-020 DATA -> TAIL on the edge that accepts bit FRAME_LEN.
REQ-021 TAIL: when free, encoder injects d=0 internally (no din handshake), loads sym and sets sym_valid; exactly 2 tail bits, returning encoder state to 00.
REQ-022 TAIL -> DONE on the edge where the second tail symbol is taken by the consumer (sym_valid && sym_ready with tail count = 2).
REQ-023 DONE: done = 1 for exactly one cycle, then -> IDLE unconditionally; st in DONE ignored.
REQ-024 sym_valid clears on a handshake edge when no new symbol loads in that edge; simultaneous handshake and load keeps sym_valid = 1 with new sym (full throughput, one symbol per cycle).
REQ-025 While sym_valid=1 and sym_ready=0, sym and sym_valid remain stable.
REQ-026 st asserted while busy=1 is ignored; no frame restart.
REQ-027 din_valid with din_ready=0 has no effect; din is not sampled.
REQ-028 Bit counter width ceil(log2(FRAME_LEN+1)); counter never wraps within a frame.
REQ-029 Each frame emits exactly FRAME_LEN+2 symbols.

Reset
REQ-030 rst=1 at any edge, including mid-frame: state IDLE, encoder state 00, counters 0, sym=00, sym_valid=0, din_ready=0, busy=0, done=0; partial frame discarded.
REQ-031 rst has priority over all other inputs in the same cycle.

Verification
REQ-032 FRAME_LEN=4, sym_ready=1, din 1,0,1,1 back-to-back -> sym 11,10,00,01 then tail 01,11; done pulses once; 6 symbols total.
REQ-033 Same frame with sym_ready held 0 for 3 cycles after first symbol -> sym stays 11, sym_valid=1, din_ready=0 during stall; final sequence unchanged.
REQ-034 FRAME_LEN=8, din all 0 -> 10 symbols, all 00; encoder state ends 00.
REQ-035 rst asserted after 2 of 4 data bits accepted -> next cycle all outputs at reset values; new st restarts a clean frame whose symbols match REQ-032 for the same data.
REQ-036 st pulsed during DATA and during DONE -> no effect on symbol count or sequence; done pulses exactly once per frame.
REQ-037 din_valid toggled randomly, sym_ready random -> output symbol stream equals golden (7,5) model of the data bits plus two zero tail bits.
